nmr_shot_scheduler: RTL and testbench

NMR_SHOT_SCHEDULER -- requirements
Module: nmr_shot_scheduler

---
 rtl/nmr_shot_scheduler.sv | 135 +++++++++++++
 tb/tb_nmr_shot_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_shot_scheduler.sv
// Sequences a run of NMR acquisition shots: arms the acquisition FSM, waits for its
// done flag (with optional timeout), then waits a recovery delay and steps the frequency.
module nmr_shot_scheduler #(
    parameter int SHOT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [SHOT_W-1:0] nb_shots_i,
    input  logic [31:0]       tr_delay_i,
    input  logic [31:0]       timeout_i,
    input  logic [31:0]       freq_start_i,
    input  logic [31:0]       freq_step_i,
    input  logic              acq_done_i,
    output logic              acq_start_o,
    output logic              acq_rst_n_o,
    output logic [31:0]       freq_o,
    output logic [SHOT_W-1:0] shot_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_err_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    logic [2:0]        r_state;
    logic              r_startQ;
    logic [31:0]       r_timer;
    logic [SHOT_W-1:0] r_nbShots;
    logic [31:0]       r_trDelay;
    logic [31:0]       r_timeout;
    logic [31:0]       r_freqStep;

    logic [2:0]        w_nextState;
    logic              w_startEdge;
    logic [31:0]       w_timerInc;
    logic [SHOT_W-1:0] w_cntInc;
    logic              w_timeoutHit;

    assign w_startEdge  = start_i & ~r_startQ;
    assign w_timerInc   = r_timer + 32'd1;
    assign w_cntInc     = (&shot_cnt_o) ? shot_cnt_o : shot_cnt_o + SHOT_W'(1);
    // The timer counts cycles since ARM, so the hit fires on the edge that ends cycle ARM+timeout-1.
    assign w_timeoutHit = (r_timeout != 32'd0) && (w_timerInc >= r_timeout);

    always_comb begin
        w_nextState = r_state;
        if (abort_i) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_startEdge) w_nextState = S_LOAD;
                S_LOAD:    w_nextState = (r_nbShots == '0) ? S_FINISH : S_ARM;
                S_ARM:     w_nextState = S_WAIT;
                S_WAIT: begin
                    if (acq_done_i)
                        w_nextState = (w_cntInc == r_nbShots) ? S_FINISH : S_RECOVER;
                    else if (w_timeoutHit)
                        w_nextState = S_ERROR;
                end
                S_RECOVER: if (r_timer >= r_trDelay) w_nextState = S_ARM;
                S_FINISH:  if (w_startEdge) w_nextState = S_LOAD;
                S_ERROR:   w_nextState = S_ERROR;
                default:   w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_startQ      <= 1'b0;
            r_timer       <= 32'd0;
            r_nbShots     <= '0;
            r_trDelay     <= 32'd0;
            r_timeout     <= 32'd0;
            r_freqStep    <= 32'd0;
            shot_cnt_o    <= '0;
            freq_o        <= 32'd0;
            acq_start_o   <= 1'b0;
            acq_rst_n_o   <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            r_startQ      <= start_i;
            r_state       <= w_nextState;
            acq_start_o   <= (w_nextState == S_ARM);
            busy_o        <= (w_nextState == S_LOAD) || (w_nextState == S_ARM) ||
                             (w_nextState == S_WAIT) || (w_nextState == S_RECOVER);
            done_o        <= (w_nextState == S_FINISH);
            timeout_err_o <= (w_nextState == S_ERROR);

            // Held low on abort and for only the first RECOVER cycle.
            case (w_nextState)
                S_IDLE:         acq_rst_n_o <= ~abort_i;
                S_LOAD,
                S_ERROR:        acq_rst_n_o <= 1'b0;
                S_RECOVER:      acq_rst_n_o <= (r_state == S_RECOVER);
                default:        acq_rst_n_o <= 1'b1;
            endcase

            if (w_nextState == S_LOAD) begin
                r_nbShots  <= nb_shots_i;
                r_trDelay  <= tr_delay_i;
                r_timeout  <= timeout_i;
                r_freqStep <= freq_step_i;
                freq_o     <= freq_start_i;
            end else if (r_state == S_RECOVER && w_nextState == S_ARM) begin
                freq_o <= freq_o + r_freqStep;
            end

            if (abort_i || w_nextState == S_LOAD)
                shot_cnt_o <= '0;
            else if (r_state == S_WAIT && acq_done_i)
                shot_cnt_o <= w_cntInc;

            if ((w_nextState == S_ARM && r_state != S_ARM) ||
                (w_nextState == S_RECOVER && r_state != S_RECOVER))
                r_timer <= 32'd0;
            else if (r_state == S_ARM || r_state == S_WAIT || r_state == S_RECOVER)
                r_timer <= w_timerInc;
            else
                r_timer <= 32'd0;
        end
    end

endmodule

// File: tb/tb_nmr_shot_scheduler.sv
// Directed bench for nmr_shot_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_nmr_shot_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [15:0] nb_shots_i;
    logic [31:0] tr_delay_i;
    logic [31:0] timeout_i;
    logic [31:0] freq_start_i;
    logic [31:0] freq_step_i;
    logic        acq_done_i;
    logic        acq_start_o;
    logic        acq_rst_n_o;
    logic [31:0] freq_o;
    logic [15:0] shot_cnt_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulseCount = 0;

    nmr_shot_scheduler #(.SHOT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .nb_shots_i(nb_shots_i), .tr_delay_i(tr_delay_i), .timeout_i(timeout_i),
        .freq_start_i(freq_start_i), .freq_step_i(freq_step_i), .acq_done_i(acq_done_i),
        .acq_start_o(acq_start_o), .acq_rst_n_o(acq_rst_n_o), .freq_o(freq_o),
        .shot_cnt_o(shot_cnt_o), .busy_o(busy_o), .done_o(done_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acq_start_o) pulseCount <= pulseCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] nb, input logic [31:0] tr, input logic [31:0] to,
                                 input logic [31:0] fs, input logic [31:0] fstep);
        nb_shots_i   = nb;
        tr_delay_i   = tr;
        timeout_i    = to;
        freq_start_i = fs;
        freq_step_i  = fstep;
    endtask

    // Raises start for one cycle; returns at the falling edge inside the LOAD cycle.
    task automatic pulseStart();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic waitStart(input string tag, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acq_start_o && n < 200);
        at = cyc;
        checkOutput({tag, "_seen"}, 64'(acq_start_o), 64'd1);
    endtask

    // Acquisition done is presented in cycle pulse+d; called at the pulse's falling edge.
    task automatic giveDone(input int d);
        repeat (d) @(negedge clk);
        acq_done_i = 1'b1;
        @(negedge clk);
        acq_done_i = 1'b0;
    endtask

    initial begin
        int t, prev, loadCyc, pc;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; acq_done_i = 1'b0;
        applyStimulus(16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_acq_rst_n", 64'(acq_rst_n_o), 64'd0);
        checkOutput("rst_start", 64'(acq_start_o), 64'd0);
        checkOutput("rst_freq", 64'(freq_o), 64'd0);
        checkOutput("rst_cnt", 64'(shot_cnt_o), 64'd0);
        checkOutput("rst_flags", 64'({done_o, timeout_err_o}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_acq_rst_n", 64'(acq_rst_n_o), 64'd1);

        $display("[TB] three-shot run");
        applyStimulus(16'd3, 32'd10, 32'd0, 32'd1000, 32'd5);
        pulseStart();
        loadCyc = cyc;
        checkOutput("load_busy", 64'(busy_o), 64'd1);
        checkOutput("load_acq_rst_n", 64'(acq_rst_n_o), 64'd0);
        checkOutput("load_freq", 64'(freq_o), 64'd1000);
        applyStimulus(16'd7, 32'd2, 32'd3, 32'd5555, 32'd99);
        prev = 0;
        for (int s = 0; s < 3; s++) begin
            waitStart("run1_start", t);
            if (s == 0) checkOutput("run1_latency", 64'(t - loadCyc), 64'd1);
            else        checkOutput("run1_spacing", 64'(t - prev), 64'd31);
            checkOutput("run1_freq", 64'(freq_o), 64'(1000 + 5 * s));
            checkOutput("run1_cnt", 64'(shot_cnt_o), 64'(s));
            prev = t;
            @(negedge clk);
            checkOutput("run1_pulse_width", 64'(acq_start_o), 64'd0);
            giveDone(18);
            checkOutput("run1_cnt_after", 64'(shot_cnt_o), 64'(s + 1));
            if (s < 2) checkOutput("run1_recover_rst", 64'(acq_rst_n_o), 64'd0);
        end
        checkOutput("run1_done", 64'(done_o), 64'd1);
        checkOutput("run1_busy", 64'(busy_o), 64'd0);
        checkOutput("run1_finish_rst", 64'(acq_rst_n_o), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("run1_hold_done", 64'(done_o), 64'd1);
        checkOutput("run1_hold_cnt", 64'(shot_cnt_o), 64'd3);
        checkOutput("run1_hold_freq", 64'(freq_o), 64'd1010);

        $display("[TB] zero-shot run from FINISH");
        applyStimulus(16'd0, 32'd4, 32'd0, 32'd77, 32'd1);
        pc = pulseCount;
        pulseStart();
        checkOutput("zero_load_busy", 64'(busy_o), 64'd1);
        checkOutput("zero_load_done", 64'(done_o), 64'd0);
        @(negedge clk);
        checkOutput("zero_done", 64'(done_o), 64'd1);
        checkOutput("zero_cnt", 64'(shot_cnt_o), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("zero_no_pulse", 64'(pulseCount), 64'(pc));

        $display("[TB] timeout to ERROR, then abort");
        applyStimulus(16'd2, 32'd0, 32'd50, 32'd10, 32'd1);
        pulseStart();
        waitStart("to_start", t);
        repeat (49) @(negedge clk);
        checkOutput("to_not_yet", 64'(timeout_err_o), 64'd0);
        @(negedge clk);
        checkOutput("to_err", 64'(timeout_err_o), 64'd1);
        checkOutput("to_err_rst", 64'(acq_rst_n_o), 64'd0);
        checkOutput("to_err_busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("to_err_stays", 64'(timeout_err_o), 64'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checkOutput("abort_flags", 64'({busy_o, done_o, timeout_err_o, acq_start_o}), 64'd0);
        checkOutput("abort_acq_rst_n", 64'(acq_rst_n_o), 64'd0);
        @(negedge clk);
        checkOutput("abort_idle_rst_n", 64'(acq_rst_n_o), 64'd1);

        $display("[TB] done and timeout together");
        applyStimulus(16'd1, 32'd0, 32'd50, 32'd20, 32'd1);
        pulseStart();
        waitStart("tie_start", t);
        giveDone(49);
        checkOutput("tie_no_err", 64'(timeout_err_o), 64'd0);
        checkOutput("tie_done", 64'(done_o), 64'd1);
        checkOutput("tie_cnt", 64'(shot_cnt_o), 64'd1);

        $display("[TB] abort during RECOVER");
        applyStimulus(16'd3, 32'd10, 32'd0, 32'd0, 32'd1);
        pulseStart();
        waitStart("ab_start", t);
        giveDone(19);
        checkOutput("ab_in_recover", 64'(busy_o), 64'd1);
        pc = pulseCount;
        repeat (2) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checkOutput("ab_busy", 64'(busy_o), 64'd0);
        checkOutput("ab_cnt", 64'(shot_cnt_o), 64'd0);
        checkOutput("ab_acq_rst_n", 64'(acq_rst_n_o), 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("ab_no_pulse", 64'(pulseCount), 64'(pc));

        $display("[TB] frequency wrap, start ignored while busy");
        applyStimulus(16'd2, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd3);
        pulseStart();
        waitStart("wr_start0", prev);
        checkOutput("wr_freq0", 64'(freq_o), 64'hFFFF_FFFE);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        giveDone(18);
        waitStart("wr_start1", t);
        checkOutput("wr_spacing", 64'(t - prev), 64'd21);
        checkOutput("wr_freq1", 64'(freq_o), 64'h0000_0001);
        giveDone(19);
        checkOutput("wr_done", 64'(done_o), 64'd1);
        checkOutput("wr_cnt", 64'(shot_cnt_o), 64'd2);

        $display("[TB] reset mid-run");
        applyStimulus(16'd3, 32'd5, 32'd0, 32'd9, 32'd1);
        pulseStart();
        waitStart("mr_start", t);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pc = pulseCount;
        checkOutput("mr_busy", 64'(busy_o), 64'd0);
        checkOutput("mr_freq", 64'(freq_o), 64'd0);
        acq_done_i = 1'b1;
        @(negedge clk);
        acq_done_i = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("mr_no_pulse", 64'(pulseCount), 64'(pc));
        checkOutput("mr_cnt", 64'(shot_cnt_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
